// File: rtl/seqgen_stream.sv
// Arithmetic-progression generator: emits a, a+STEP, ... while term <= b on a
// valid/ready stream, with start/busy/done command handshake and beat count.
//
// state  | meaning
// S_IDLE | waiting for start; a and b sampled on accept
// S_RUN  | presenting terms on the stream, one per beat
// S_DONE | one-cycle done pulse, then back to idle
module seqgen_stream #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic signed [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_r, b_d;
  logic [WIDTH-1:0] data_d, cnt_d, nxt_term;
  logic             last_d, valid_d, done_d, busy_d;

  // Bound compares run one bit wider so term+STEP can never wrap negative.
  logic signed [WIDTH:0] a_x, b_in_x, b_r_x, nxt_x;
  logic signed [WIDTH:0] a_step_x, nxt_step_x;

  assign nxt_term   = m_data + WIDTH'(STEP);
  assign a_x        = {a[WIDTH-1], a};
  assign b_in_x     = {b[WIDTH-1], b};
  assign b_r_x      = {b_r[WIDTH-1], b_r};
  assign nxt_x      = {nxt_term[WIDTH-1], nxt_term};
  assign a_step_x   = a_x + STEP_X;
  assign nxt_step_x = nxt_x + STEP_X;

  always_comb begin
    state_d = state_q;
    b_d     = b_r;
    data_d  = m_data;
    cnt_d   = count;
    last_d  = m_last;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d = a;
          b_d    = b;
          cnt_d  = '0;
          if (a_x > b_in_x) begin
            state_d = S_DONE;
            last_d  = 1'b0;
          end else begin
            state_d = S_RUN;
            last_d  = (a_step_x > b_in_x);
          end
        end
      end
      S_RUN: begin
        if (m_ready) begin
          cnt_d = count + WIDTH'(1);
          if (m_last) begin
            state_d = S_DONE;
            last_d  = 1'b0;
          end else begin
            // Only advance when a further term exists, so term never overflows.
            data_d = nxt_term;
            last_d = (nxt_step_x > b_r_x);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      b_r     <= '0;
      m_data  <= '0;
      count   <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      b_r     <= b_d;
      m_data  <= data_d;
      count   <= cnt_d;
      m_last  <= last_d;
      m_valid <= valid_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: doc/seqgen_stream.md
Name: seqgen_stream

Overview:
- Sequence generator. Takes a start value a and a bound b. Emits the arithmetic progression a, a+STEP, a+2·STEP, … while term ≤ b.
- Terms go out one per beat on a valid/ready stream.
- It is the producer side of the seqsum accumulator: it feeds terms to a downstream summing or consuming block.
- Command interface is start/busy/done; it reports how many terms were emitted.

Parameters:
WIDTH, 32, data width of a, b, m_data, count (signed two's complement)
STEP, 2, positive increment between consecutive terms (1 ≤ STEP < 2^(WIDTH-1))

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  command pulse; accepted only in IDLE
a  input  WIDTH  signed first term; sampled when start is accepted
b  input  WIDTH  signed inclusive upper bound; sampled when start is accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse at end of command
count  output  WIDTH  number of beats transferred for the current/last command
m_valid  output  1  stream valid
m_ready  input  1  stream ready from consumer
m_data  output  WIDTH  current term (signed)
m_last  output  1  high with the final term of the command

Behaviour:
- Reset (rst_n=0, async): state IDLE; busy, done, m_valid, m_last = 0; m_data = 0; count = 0.
- Reset mid-command aborts the command immediately. No further beats are emitted after release.
- All outputs are registered.
- State IDLE:
  - On start=1, latch a into term_r and b into b_r, and clear count.
  - If signed a > b: go to DONE. No beats are emitted.
  - Otherwise go to RUN.
  - a and b are ignored outside the accept cycle.
- State RUN:
  - m_valid=1, m_data=term_r.
  - m_last=1 when term_r + STEP > b_r. This compare is done at WIDTH+1 bits, sign-extended, so it never wraps.
  - Beat = m_valid & m_ready.
  - On a beat: count += 1. If m_last, go to DONE. Otherwise term_r += STEP.
  - Without a beat: m_data and m_last hold stable. m_valid never drops once raised until its beat completes.
- State DONE:
  - m_valid=0, done=1 for exactly one cycle, then IDLE.
  - count holds its final value until the next accepted start.
- start while busy (RUN or DONE, including the done cycle) is ignored. It is not queued.
- Latency:
  - Start accepted at edge N → m_valid high after edge N (first beat possible at edge N+1).
  - With m_ready tied high, beats occur on consecutive cycles. The done pulse occurs in the cycle after the last beat.
  - Empty command (a > b): done high the cycle after the start accept.
- Term count for a ≤ b is floor((b−a)/STEP)+1, computed without overflow. term_r never increments past the last term, so no wrap-around occurs even when b is near the maximum positive value.
- Sum of emitted terms equals seqsum(a,b) for the same a, b, STEP.
- m_ready is don't-care when m_valid=0.

Test Plan:
- a=1, b=10, m_ready=1:
  - m_data 1,3,5,7,9 on 5 consecutive cycles; m_last only with 9.
  - done the next cycle; count=5; sum of terms=25.
- a=10, b=10: single beat m_data=10 with m_last=1; done; count=1.
- a=11, b=10: no m_valid; done one cycle after start; count=0.
- a=-3, b=2, m_ready toggling 1,0,0,1,0,1:
  - beats -3, -1, 1 with m_last on 1.
  - m_data and m_valid held stable through the stalled cycles; count=3.
- a=0x7FFFFFFD, b=0x7FFFFFFF: beats 0x7FFFFFFD, then 0x7FFFFFFF with m_last; no wrap to negative; count=2.
- Abort and start filtering:
  - rst_n pulsed low after the 2nd beat of a=0, b=20 → all outputs 0 asynchronously; no beats after release.
  - A new start a=2, b=6 then yields 2,4,6, count=3.
  - A start pulsed during RUN and on the done cycle is ignored.
